// File: rtl/hex_scan_driver.sv
// hex_scan_driver: scans a 16-bit value across a 4-digit common-anode display (optional macro HEX_SCAN_LZ_BLANK_EN)
module hex_scan_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    nib_q, nib_d, an_q, an_d;
  logic          fd_q, fd_d;
  logic          tick, boundary, accept, blank;
  assign in_ready = !pend_v_q && !rst;
  assign {z, y, x, w} = nib_q;
  assign an = an_q;
  assign frame_done = fd_q;
  // Next-state: prescaler, slot index, frame-aligned display swap, pending buffer and registered outputs
  always_comb begin
    tick     = cnt_q == CW'(CLK_DIV - 1);
    boundary = tick && idx_q == 2'd3;
    accept   = in_valid && in_ready;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    disp_d   = (boundary && pend_v_q) ? pend_q : disp_q;
    pend_d   = accept ? in_data : pend_q;
    pend_v_d = accept ? 1'b1 : (boundary ? 1'b0 : pend_v_q);
`ifdef HEX_SCAN_LZ_BLANK_EN
    blank    = idx_d != 2'd0 && (disp_d >> {idx_d, 2'b00}) == 16'h0;
`else
    blank    = 1'b0;
`endif
    nib_d    = tick ? disp_d[4*idx_d +: 4] : nib_q;
    an_d     = tick ? (blank ? 4'b1111 : ~(4'b0001 << idx_d)) : an_q;
    fd_d     = boundary;
  end
  // State register; reset overrides everything and drops any pending value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      disp_q   <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      nib_q    <= 4'h0;
      an_q     <= 4'b1110;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed self-checking bench for hex_scan_driver with CLK_DIV=4
module tb_hex_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready, w, x, y, z, frame_done;
  logic [3:0]  an;
  int tests = 0, fails = 0, e = 0;

  hex_scan_driver #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w(w), .x(x), .y(y), .z(z), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected anode pattern for digit i of value v
  function automatic logic [3:0] an_exp(input logic [15:0] v, input int i);
    logic [3:0] a;
    a = ~(4'b0001 << i);
`ifdef HEX_SCAN_LZ_BLANK_EN
    if (i != 0 && (v >> (4 * i)) == 16'h0) a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] n, input logic [3:0] a);
    chk({tag, ".nib"}, {12'h0, z, y, x, w}, {12'h0, n});
    chk({tag, ".an"}, {12'h0, an}, {12'h0, a});
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic adv_to(input int t);
    adv(t - e);
  endtask

  initial begin
    adv(3);
    slot("rst", 4'h0, 4'b1110);
    chk("rst.fd", {15'h0, frame_done}, 16'h0);
    chk("rst.rdy", {15'h0, in_ready}, 16'h0);
    rst = 1'b0;
    e = 0;
    #1;
    chk("rel.rdy", {15'h0, in_ready}, 16'h1);
    for (int i = 1; i <= 3; i++) begin
      adv_to(i);
      slot("post_rst", 4'h0, 4'b1110);
    end
    adv_to(4);
    slot("tick4", 4'h0, an_exp(16'h0, 1));
    adv_to(15);
    chk("fd15", {15'h0, frame_done}, 16'h0);
    adv_to(16);
    chk("fd16", {15'h0, frame_done}, 16'h1);
    slot("wrap16", 4'h0, 4'b1110);
    adv_to(17);
    chk("fd17", {15'h0, frame_done}, 16'h0);
    // mid-frame accept of A3F5
    in_data = 16'hA3F5;
    in_valid = 1'b1;
    adv_to(18);
    in_valid = 1'b0;
    chk("a3.rdy_lo", {15'h0, in_ready}, 16'h0);
    adv_to(20); slot("a3.old1", 4'h0, an_exp(16'h0, 1));
    adv_to(24); slot("a3.old2", 4'h0, an_exp(16'h0, 2));
    adv_to(28); slot("a3.old3", 4'h0, an_exp(16'h0, 3));
    adv_to(31); chk("a3.rdy31", {15'h0, in_ready}, 16'h0);
    adv_to(32); slot("a3.d0", 4'h5, 4'b1110);
    chk("a3.rdy_hi", {15'h0, in_ready}, 16'h1);
    chk("a3.fd", {15'h0, frame_done}, 16'h1);
    adv_to(36); slot("a3.d1", 4'hF, 4'b1101);
    adv_to(40); slot("a3.d2", 4'h3, 4'b1011);
    adv_to(44); slot("a3.d3", 4'hA, 4'b0111);
    // back-to-back 1234 then 5678
    adv_to(45);
    in_data = 16'h1234;
    in_valid = 1'b1;
    adv_to(46);
    in_data = 16'h5678;
    chk("bb.rdy46", {15'h0, in_ready}, 16'h0);
    adv_to(47); chk("bb.rdy47", {15'h0, in_ready}, 16'h0);
    adv_to(48); slot("bb.1_d0", 4'h4, 4'b1110);
    chk("bb.rdy48", {15'h0, in_ready}, 16'h1);
    adv_to(49);
    in_valid = 1'b0;
    chk("bb.rdy49", {15'h0, in_ready}, 16'h0);
    adv_to(52); slot("bb.1_d1", 4'h3, 4'b1101);
    adv_to(56); slot("bb.1_d2", 4'h2, 4'b1011);
    adv_to(60); slot("bb.1_d3", 4'h1, 4'b0111);
    adv_to(64); slot("bb.5_d0", 4'h8, 4'b1110);
    adv_to(68); slot("bb.5_d1", 4'h7, 4'b1101);
    adv_to(72); slot("bb.5_d2", 4'h6, 4'b1011);
    adv_to(76); slot("bb.5_d3", 4'h5, 4'b0111);
    // BEEF offered on the boundary cycle
    adv_to(79);
    in_data = 16'hBEEF;
    in_valid = 1'b1;
    adv_to(80);
    in_valid = 1'b0;
    slot("be.cur_d0", 4'h8, 4'b1110);
    chk("be.rdy", {15'h0, in_ready}, 16'h0);
    chk("be.fd", {15'h0, frame_done}, 16'h1);
    adv_to(84); slot("be.cur_d1", 4'h7, 4'b1101);
    adv_to(92); slot("be.cur_d3", 4'h5, 4'b0111);
    adv_to(96); slot("be.d0", 4'hF, 4'b1110);
    adv_to(100); slot("be.d1", 4'hE, 4'b1101);
    adv_to(104); slot("be.d2", 4'hE, 4'b1011);
    adv_to(108); slot("be.d3", 4'hB, 4'b0111);
    // reset while a value is pending
    adv_to(109);
    in_data = 16'hC0DE;
    in_valid = 1'b1;
    adv_to(110);
    in_valid = 1'b0;
    chk("rp.rdy_lo", {15'h0, in_ready}, 16'h0);
    rst = 1'b1;
    adv_to(111);
    slot("rp.rst", 4'h0, 4'b1110);
    chk("rp.fd", {15'h0, frame_done}, 16'h0);
    rst = 1'b0;
    #1;
    chk("rp.rdy_hi", {15'h0, in_ready}, 16'h1);
    adv_to(115); slot("rp.d1", 4'h0, an_exp(16'h0, 1));
    adv_to(119); slot("rp.d2", 4'h0, an_exp(16'h0, 2));
    adv_to(123); slot("rp.d3", 4'h0, an_exp(16'h0, 3));
    adv_to(127); slot("rp.d0", 4'h0, 4'b1110);
    chk("rp.fd127", {15'h0, frame_done}, 16'h1);
`ifdef HEX_SCAN_LZ_BLANK_EN
    in_data = 16'h0070;
    in_valid = 1'b1;
    adv_to(128);
    in_valid = 1'b0;
    adv_to(143); slot("lz.70_d0", 4'h0, 4'b1110);
    adv_to(147); slot("lz.70_d1", 4'h7, 4'b1101);
    adv_to(151); slot("lz.70_d2", 4'h0, 4'b1111);
    adv_to(155); slot("lz.70_d3", 4'h0, 4'b1111);
    in_data = 16'h0000;
    in_valid = 1'b1;
    adv_to(156);
    in_valid = 1'b0;
    adv_to(159); slot("lz.0_d0", 4'h0, 4'b1110);
    adv_to(163); slot("lz.0_d1", 4'h0, 4'b1111);
    adv_to(167); slot("lz.0_d2", 4'h0, 4'b1111);
    adv_to(171); slot("lz.0_d3", 4'h0, 4'b1111);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
